// File: rtl/multicycle_seq.sv
// multicycle_seq: multi-cycle fetch/decode/exec/wb sequencer for the ALU-only MIPS datapath
//   CLK, Reset_L                 clock, asynchronous active-low reset
//   run                          level enable for fetching
//   imem_req/addr/ack/rdata      instruction-memory handshake (rdata valid with ack)
//   instr                        instruction register
//   ALUOp, ALUSrcB, RegDst       registered datapath controls, held DECODE..WB
//   RegWrite                     register-file write strobe, WB only
//   alu_overflow                 ALU signed-overflow flag, sampled in EXEC
//   busy, trap, trap_cause       status (cause 1 = illegal, 2 = overflow)
//   retired                      completed-instruction counter
module multicycle_seq #(
  parameter logic [31:0] START_PC = 32'h0000_0000,
  parameter int          RETIRE_W = 16
) (
  input  logic                CLK,
  input  logic                Reset_L,
  input  logic                run,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  output logic [3:0]          ALUOp,
  output logic                ALUSrcB,
  output logic                RegDst,
  output logic                RegWrite,
  input  logic                alu_overflow,
  output logic                busy,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [RETIRE_W-1:0] retired
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDU = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_NOP  = 4'd15;
  // control bundle is {ALUOp, ALUSrcB, RegDst}
  localparam logic [5:0] CTRL_RST = {OP_NOP, 2'b00};
  logic [2:0]          r_state;
  logic [31:0]         r_pc;
  logic [31:0]         r_ir;
  logic [5:0]          r_ctrl;
  logic                r_illegal;
  logic [1:0]          r_cause;
  logic [RETIRE_W-1:0] r_retired;
  logic [5:0]          w_opc;
  logic [5:0]          w_fn;
  logic [5:0]          w_ctrl;
  logic                w_illegal;
  logic                w_ovf_op;
  assign w_opc = imem_rdata[31:26];
  assign w_fn  = imem_rdata[5:0];
  // Decode straight from the memory word so controls are already valid on
  // DECODE entry and stay untouched until WB exits.
  always_comb begin
    w_illegal = 1'b0;
    w_ctrl    = CTRL_RST;
    if (w_opc == 6'h00) begin
      case (w_fn)
        6'h00:   w_ctrl = {OP_SLL,  2'b11};
        6'h02:   w_ctrl = {OP_SRL,  2'b11};
        6'h03:   w_ctrl = {OP_SRA,  2'b11};
        6'h20:   w_ctrl = {OP_ADD,  2'b01};
        6'h21:   w_ctrl = {OP_ADDU, 2'b01};
        6'h22:   w_ctrl = {OP_SUB,  2'b01};
        6'h23:   w_ctrl = {OP_SUBU, 2'b01};
        6'h24:   w_ctrl = {OP_AND,  2'b01};
        6'h25:   w_ctrl = {OP_OR,   2'b01};
        6'h26:   w_ctrl = {OP_XOR,  2'b01};
        6'h2A:   w_ctrl = {OP_SLT,  2'b01};
        6'h2B:   w_ctrl = {OP_SLTU, 2'b01};
        default: w_illegal = 1'b1;
      endcase
    end else begin
      case (w_opc)
        6'h08:   w_ctrl = {OP_ADD,  2'b10};
        6'h09:   w_ctrl = {OP_ADDU, 2'b10};
        6'h0A:   w_ctrl = {OP_SLT,  2'b10};
        6'h0B:   w_ctrl = {OP_SLTU, 2'b10};
        6'h0C:   w_ctrl = {OP_AND,  2'b10};
        6'h0D:   w_ctrl = {OP_OR,   2'b10};
        6'h0E:   w_ctrl = {OP_XOR,  2'b10};
        default: w_illegal = 1'b1;
      endcase
    end
  end
  assign w_ovf_op = (r_ctrl[5:2] == OP_ADD) || (r_ctrl[5:2] == OP_SUB);
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state   <= S_IDLE;
      r_pc      <= START_PC;
      r_ir      <= '0;
      r_ctrl    <= CTRL_RST;
      r_illegal <= 1'b0;
      r_cause   <= 2'd0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (run) r_state <= S_FETCH;
        S_FETCH: if (imem_ack) begin
          r_ir      <= imem_rdata;
          r_ctrl    <= w_ctrl;
          r_illegal <= w_illegal;
          r_state   <= S_DECODE;
        end
        S_DECODE: begin
          r_state <= r_illegal ? S_TRAP : S_EXEC;
          r_cause <= r_illegal ? 2'd1 : 2'd0;
        end
        S_EXEC: if (w_ovf_op && alu_overflow) begin
          r_state <= S_TRAP;
          r_cause <= 2'd2;
          r_ctrl  <= CTRL_RST;
        end else begin
          r_state <= S_WB;
        end
        S_WB: begin
          r_pc      <= r_pc + 32'd4;
          r_retired <= r_retired + 1'b1;
          r_state   <= run ? S_FETCH : S_IDLE;
          r_ctrl    <= run ? r_ctrl : CTRL_RST;
        end
        default: ;
      endcase
    end
  end
  assign imem_req   = r_state == S_FETCH;
  assign imem_addr  = r_pc;
  assign instr      = r_ir;
  assign {ALUOp, ALUSrcB, RegDst} = r_ctrl;
  assign RegWrite   = r_state == S_WB;
  assign busy       = (r_state != S_IDLE) && (r_state != S_TRAP);
  assign trap       = r_state == S_TRAP;
  assign trap_cause = r_cause;
  assign retired    = r_retired;
endmodule

// File: tb/tb_multicycle_seq.sv
// tb_multicycle_seq: randomized self-checking bench for multicycle_seq against a behavioural model
module tb_multicycle_seq;
  localparam logic [3:0] A_ADD = 4'd0, A_ADDU = 4'd1, A_SUB = 4'd2, A_SUBU = 4'd3;
  localparam logic [3:0] A_AND = 4'd4, A_OR = 4'd5, A_XOR = 4'd6, A_SLL = 4'd7;
  localparam logic [3:0] A_SRL = 4'd8, A_SRA = 4'd9, A_SLT = 4'd10, A_SLTU = 4'd11, A_NOP = 4'd15;
  localparam logic [3:0] ARITH[7] = '{A_ADD, A_ADDU, A_SUB, A_SUBU, A_AND, A_OR, A_XOR};
  localparam logic [3:0] IMM[7]   = '{A_ADD, A_ADDU, A_SLT, A_SLTU, A_AND, A_OR, A_XOR};
  localparam logic [5:0] RFN[12]  = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B};
  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        alu_overflow = 1'b0;
  logic        imem_req, ALUSrcB, RegDst, RegWrite, busy, trap;
  logic [31:0] imem_addr, instr;
  logic [3:0]  ALUOp;
  logic [1:0]  trap_cause;
  logic [15:0] retired;
  logic        wr_req, wr_srcb, wr_dst, wr_rw, wr_busy, wr_trap;
  logic [31:0] wr_addr, wr_instr;
  logic [3:0]  wr_op;
  logic [1:0]  wr_cause;
  logic [15:0] wr_ret;
  int total = 0;
  int bad = 0;
  logic [31:0] m_pc;
  logic [15:0] m_ret;
  logic        m_trap;
  logic [1:0]  m_cause;
  int          e_rw;
  int          obs_req, obs_rw, obs_rw_at;
  logic        obs_req_dec, obs_stable, obs_srcb, obs_dst;
  logic [3:0]  obs_op;
  multicycle_seq u_dut (
    .CLK(CLK), .Reset_L(Reset_L), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .RegDst(RegDst), .RegWrite(RegWrite), .alu_overflow(alu_overflow),
    .busy(busy), .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );
  multicycle_seq #(.START_PC(32'hFFFF_FFFC)) u_wrap (
    .CLK(CLK), .Reset_L(Reset_L), .run(run), .imem_req(wr_req), .imem_addr(wr_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(wr_instr), .ALUOp(wr_op),
    .ALUSrcB(wr_srcb), .RegDst(wr_dst), .RegWrite(wr_rw), .alu_overflow(alu_overflow),
    .busy(wr_busy), .trap(wr_trap), .trap_cause(wr_cause), .retired(wr_ret)
  );
  always #5 CLK = ~CLK;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  // {legal, aluop, srcb, regdst} straight from the opcode/funct tables
  function automatic logic [6:0] exp_dec(input logic [31:0] iw);
    logic [5:0] o;
    logic [5:0] f;
    o = iw[31:26];
    f = iw[5:0];
    if (o == 6'h00) begin
      if (f == 6'h00) return {1'b1, A_SLL, 2'b11};
      if (f == 6'h02) return {1'b1, A_SRL, 2'b11};
      if (f == 6'h03) return {1'b1, A_SRA, 2'b11};
      if (f >= 6'h20 && f <= 6'h26) return {1'b1, ARITH[int'(f) - 32], 2'b01};
      if (f == 6'h2A) return {1'b1, A_SLT, 2'b01};
      if (f == 6'h2B) return {1'b1, A_SLTU, 2'b01};
      return {1'b0, A_NOP, 2'b00};
    end
    if (o >= 6'h08 && o <= 6'h0E) return {1'b1, IMM[int'(o) - 8], 2'b10};
    return {1'b0, A_NOP, 2'b00};
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 9);
    if (r == 0) return w;
    if (r < 5) return {6'h00, w[25:6], RFN[$urandom_range(0, 11)]};
    return {6'h08 + 6'($urandom_range(0, 6)), w[25:0]};
  endfunction
  task automatic model_apply(input logic [31:0] iw, input logic ovf);
    logic [6:0] d;
    d = exp_dec(iw);
    e_rw = 0;
    if (!d[6]) begin
      m_trap = 1'b1; m_cause = 2'd1;
    end else if (ovf && (d[5:2] == A_ADD || d[5:2] == A_SUB)) begin
      m_trap = 1'b1; m_cause = 2'd2;
    end else begin
      m_pc = m_pc + 32'd4; m_ret = m_ret + 16'd1; e_rw = 1;
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask
  task automatic do_reset;
    Reset_L = 1'b0;
    imem_ack = 1'b0;
    tick;
    Reset_L = 1'b1;
    m_pc = '0; m_ret = '0; m_trap = 1'b0; m_cause = 2'd0;
  endtask
  // Starts in FETCH (cycle 1); answers after wt idle cycles, then walks DECODE/EXEC/WB-or-TRAP.
  task automatic exec_one(input logic [31:0] iw, input int wt, input logic ovf, input bit drop);
    int c;
    c = 1; obs_req = 0; obs_rw = 0; obs_rw_at = 0; obs_stable = 1'b1;
    alu_overflow = ovf;
    for (int k = 0; k < wt; k++) begin
      obs_req += int'(imem_req); obs_rw += int'(RegWrite);
      imem_rdata = $urandom;
      tick; c++;
    end
    obs_req += int'(imem_req); obs_rw += int'(RegWrite);
    imem_ack = 1'b1; imem_rdata = iw;
    tick; c++;
    imem_ack = 1'b0; imem_rdata = $urandom;
    obs_req_dec = imem_req; obs_op = ALUOp; obs_srcb = ALUSrcB; obs_dst = RegDst;
    for (int k = 0; k < 3; k++) begin
      if (RegWrite) begin obs_rw++; obs_rw_at = c; end
      if (!trap && {ALUOp, ALUSrcB, RegDst} !== {obs_op, obs_srcb, obs_dst}) obs_stable = 1'b0;
      if (drop && k == 1) run = 1'b0;
      tick; c++;
    end
    alu_overflow = 1'($urandom);
  endtask
  task automatic test_reset;
    run = 1'b1;
    tick; tick;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_ir got=%h exp=0", instr); end
    total++; if ({ALUOp, ALUSrcB, RegDst, RegWrite} !== {A_NOP, 3'b000}) begin bad++; $display("FAIL rst_ctrl got=%h/%b%b%b exp=%h/000", ALUOp, ALUSrcB, RegDst, RegWrite, A_NOP); end
    total++; if ({busy, trap, trap_cause} !== 4'b0) begin bad++; $display("FAIL rst_status got=%b%b%0d exp=000", busy, trap, trap_cause); end
    total++; if (retired !== 16'h0) begin bad++; $display("FAIL rst_retired got=%0d exp=0", retired); end
    Reset_L = 1'b1;
    tick;
    total++; if ({imem_req, busy} !== 2'b11) begin bad++; $display("FAIL rst_release got=%b%b exp=11", imem_req, busy); end
    tick;
    #2 Reset_L = 1'b0;
    #1;
    total++; if ({imem_req, busy} !== 2'b00) begin bad++; $display("FAIL rst_async got=%b%b exp=00", imem_req, busy); end
    @(negedge CLK);
    Reset_L = 1'b1;
    m_pc = '0; m_ret = '0; m_trap = 1'b0; m_cause = 2'd0;
  endtask
  task automatic test_addi;
    do_reset; run = 1'b1;
    tick;
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin bad++; $display("FAIL addi_c1 got=%b/%h exp=1/0", imem_req, imem_addr); end
    model_apply(32'h2002_0005, 1'b0);
    exec_one(32'h2002_0005, 0, 1'b0, 1'b0);
    total++; if ({obs_op, obs_srcb, obs_dst} !== {A_ADD, 2'b10}) begin bad++; $display("FAIL addi_dec got=%h/%b%b exp=%h/10", obs_op, obs_srcb, obs_dst, A_ADD); end
    total++; if (obs_rw !== 1 || obs_rw_at !== 4) begin bad++; $display("FAIL addi_rw got=%0d@%0d exp=1@4", obs_rw, obs_rw_at); end
    total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL addi_pc got=%h exp=%h", imem_addr, m_pc); end
    total++; if (retired !== m_ret) begin bad++; $display("FAIL addi_ret got=%0d exp=%0d", retired, m_ret); end
  endtask
  task automatic test_add_delayed;
    model_apply(32'h0022_1820, 1'b0);
    exec_one(32'h0022_1820, 3, 1'b0, 1'b0);
    total++; if (obs_req !== 4 || obs_req_dec !== 1'b0) begin bad++; $display("FAIL dly_req got=%0d/%b exp=4/0", obs_req, obs_req_dec); end
    total++; if ({obs_op, obs_srcb, obs_dst} !== {A_ADD, 2'b01}) begin bad++; $display("FAIL dly_dec got=%h/%b%b exp=%h/01", obs_op, obs_srcb, obs_dst, A_ADD); end
    total++; if (obs_rw !== 1 || obs_rw_at !== 7) begin bad++; $display("FAIL dly_rw got=%0d@%0d exp=1@7", obs_rw, obs_rw_at); end
    total++; if (obs_stable !== 1'b1) begin bad++; $display("FAIL dly_stable got=%b exp=1", obs_stable); end
    total++; if ({imem_addr, retired} !== {m_pc, m_ret}) begin bad++; $display("FAIL dly_state got=%h/%0d exp=%h/%0d", imem_addr, retired, m_pc, m_ret); end
  endtask
  task automatic test_sll_andi;
    do_reset; run = 1'b1;
    tick;
    model_apply(32'h0002_20C0, 1'b0);
    exec_one(32'h0002_20C0, 0, 1'b0, 1'b0);
    total++; if ({obs_op, obs_srcb, obs_dst} !== {A_SLL, 2'b11}) begin bad++; $display("FAIL sll_dec got=%h/%b%b exp=%h/11", obs_op, obs_srcb, obs_dst, A_SLL); end
    model_apply(32'h3021_000F, 1'b0);
    exec_one(32'h3021_000F, 0, 1'b0, 1'b0);
    total++; if ({obs_op, obs_srcb, obs_dst} !== {A_AND, 2'b10}) begin bad++; $display("FAIL andi_dec got=%h/%b%b exp=%h/10", obs_op, obs_srcb, obs_dst, A_AND); end
    total++; if (retired !== 16'd2 || retired !== m_ret) begin bad++; $display("FAIL pair_ret got=%0d exp=%0d", retired, m_ret); end
  endtask
  task automatic test_illegal;
    do_reset; run = 1'b1;
    tick;
    model_apply(32'hFC00_0000, 1'b0);
    exec_one(32'hFC00_0000, 1, 1'b0, 1'b0);
    total++; if ({trap, trap_cause} !== {m_trap, m_cause}) begin bad++; $display("FAIL ill_trap got=%b/%0d exp=%b/%0d", trap, trap_cause, m_trap, m_cause); end
    total++; if (obs_rw !== 0) begin bad++; $display("FAIL ill_rw got=%0d exp=0", obs_rw); end
    total++; if ({imem_addr, retired} !== {m_pc, m_ret}) begin bad++; $display("FAIL ill_pc got=%h/%0d exp=%h/%0d", imem_addr, retired, m_pc, m_ret); end
    total++; if ({busy, ALUOp, ALUSrcB, RegDst} !== {1'b0, A_NOP, 2'b00}) begin bad++; $display("FAIL ill_ctrl got=%b/%h%b%b exp=0/%h00", busy, ALUOp, ALUSrcB, RegDst, A_NOP); end
    for (int k = 0; k < 6; k++) begin run = ~run; imem_ack = 1'($urandom); tick; end
    imem_ack = 1'b0;
    total++; if ({trap, imem_req, busy, RegWrite, imem_addr} !== {4'b1000, m_pc}) begin bad++; $display("FAIL ill_hold got=%b%b%b%b/%h exp=1000/%h", trap, imem_req, busy, RegWrite, imem_addr, m_pc); end
    do_reset;
    total++; if ({trap, trap_cause} !== 3'b0) begin bad++; $display("FAIL ill_clear got=%b/%0d exp=0/0", trap, trap_cause); end
    run = 1'b1;
  endtask
  task automatic test_overflow;
    do_reset; run = 1'b1;
    tick;
    model_apply(32'h0022_1820, 1'b1);
    exec_one(32'h0022_1820, 0, 1'b1, 1'b0);
    total++; if ({trap, trap_cause} !== {1'b1, 2'd2}) begin bad++; $display("FAIL ovf_trap got=%b/%0d exp=1/2", trap, trap_cause); end
    total++; if (obs_rw !== 0 || retired !== m_ret) begin bad++; $display("FAIL ovf_rw got=%0d/%0d exp=0/%0d", obs_rw, retired, m_ret); end
    do_reset; run = 1'b1;
    tick;
    model_apply(32'h0022_1821, 1'b1);
    exec_one(32'h0022_1821, 0, 1'b1, 1'b0);
    total++; if ({trap, obs_rw, retired} !== {1'b0, 32'd1, m_ret}) begin bad++; $display("FAIL addu_ovf got=%b/%0d/%0d exp=0/1/%0d", trap, obs_rw, retired, m_ret); end
  endtask
  task automatic test_wrap;
    do_reset; run = 1'b1;
    total++; if (wr_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_start got=%h exp=fffffffc", wr_addr); end
    total++; if ({wr_req, wr_instr, wr_op, wr_srcb, wr_dst, wr_rw, wr_busy, wr_trap, wr_cause, wr_ret} !== {1'b0, 32'h0, A_NOP, 7'b0, 16'h0}) begin bad++; $display("FAIL wrap_rst got=%b/%h/%h/%b%b%b%b%b/%0d/%0d exp=0/0/%h/00000/0/0", wr_req, wr_instr, wr_op, wr_srcb, wr_dst, wr_rw, wr_busy, wr_trap, wr_cause, wr_ret, A_NOP); end
    tick;
    model_apply(32'h2002_0005, 1'b0);
    exec_one(32'h2002_0005, 0, 1'b0, 1'b0);
    total++; if (wr_addr !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", wr_addr); end
  endtask
  task automatic test_run_drop;
    do_reset; run = 1'b1;
    tick;
    model_apply(32'h0022_1825, 1'b0);
    exec_one(32'h0022_1825, 1, 1'b0, 1'b1);
    total++; if (obs_rw !== 1 || retired !== m_ret || imem_addr !== m_pc) begin bad++; $display("FAIL drop_wb got=%0d/%0d/%h exp=1/%0d/%h", obs_rw, retired, imem_addr, m_ret, m_pc); end
    tick; tick;
    total++; if ({busy, imem_req, ALUOp} !== {2'b00, A_NOP}) begin bad++; $display("FAIL drop_idle got=%b%b/%h exp=00/%h", busy, imem_req, ALUOp, A_NOP); end
    run = 1'b1;
  endtask
  task automatic test_reset_midexec;
    do_reset; run = 1'b1;
    tick;
    imem_ack = 1'b1; imem_rdata = 32'h0022_1820;
    tick;
    imem_ack = 1'b0;
    tick;
    total++; if ({busy, RegWrite, ALUOp} !== {2'b10, A_ADD}) begin bad++; $display("FAIL mid_exec got=%b%b/%h exp=10/%h", busy, RegWrite, ALUOp, A_ADD); end
    #2 Reset_L = 1'b0;
    #1;
    total++; if ({busy, RegWrite, ALUOp, instr, imem_addr} !== {2'b00, A_NOP, 64'h0}) begin bad++; $display("FAIL mid_async got=%b%b/%h/%h/%h exp=00/%h/0/0", busy, RegWrite, ALUOp, instr, imem_addr, A_NOP); end
    @(posedge CLK); #1;
    total++; if ({RegWrite, retired} !== 17'h0) begin bad++; $display("FAIL mid_nowrite got=%b/%0d exp=0/0", RegWrite, retired); end
    @(negedge CLK);
    Reset_L = 1'b1;
    m_pc = '0; m_ret = '0; m_trap = 1'b0; m_cause = 2'd0;
  endtask
  task automatic test_random;
    logic [31:0] iw;
    logic [6:0]  d;
    logic        ovf;
    int          wt;
    do_reset; run = 1'b1;
    tick;
    for (int i = 0; i < 60; i++) begin
      iw = rand_instr();
      wt = $urandom_range(0, 3);
      ovf = 1'($urandom);
      d = exp_dec(iw);
      model_apply(iw, ovf);
      exec_one(iw, wt, ovf, 1'b0);
      total++; if (obs_req !== wt + 1) begin bad++; $display("FAIL rnd_req[%0d] got=%0d exp=%0d", i, obs_req, wt + 1); end
      total++; if (obs_rw !== e_rw || (e_rw == 1 && obs_rw_at !== 4 + wt)) begin bad++; $display("FAIL rnd_rw[%0d] iw=%h got=%0d@%0d exp=%0d@%0d", i, iw, obs_rw, obs_rw_at, e_rw, 4 + wt); end
      if (d[6]) begin
        total++; if ({obs_op, obs_srcb, obs_dst} !== d[5:0]) begin bad++; $display("FAIL rnd_dec[%0d] iw=%h got=%h/%b%b exp=%h/%b%b", i, iw, obs_op, obs_srcb, obs_dst, d[5:2], d[1], d[0]); end
      end
      total++; if (obs_stable !== 1'b1) begin bad++; $display("FAIL rnd_stable[%0d] got=%b exp=1", i, obs_stable); end
      total++; if ({imem_addr, retired} !== {m_pc, m_ret}) begin bad++; $display("FAIL rnd_state[%0d] got=%h/%0d exp=%h/%0d", i, imem_addr, retired, m_pc, m_ret); end
      total++; if ({trap, trap_cause} !== {m_trap, m_cause}) begin bad++; $display("FAIL rnd_trap[%0d] iw=%h got=%b/%0d exp=%b/%0d", i, iw, trap, trap_cause, m_trap, m_cause); end
      if (m_trap) begin do_reset; tick; end
    end
  endtask
  initial begin
    @(negedge CLK);
    test_reset;
    test_addi;
    test_add_delayed;
    test_sll_andi;
    test_illegal;
    test_overflow;
    test_wrap;
    test_run_drop;
    test_reset_midexec;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
